// File: rtl/sd_cmd_host_if.sv
// Command/response handshake between an SD command issuer and sd_cmd_host.
// The master issues commands; the slave (sd_cmd_host) accepts them and returns responses.
interface sd_cmd_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        resp_long;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        resp_timeout;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, cmd_crc, resp_long,
    input  cmd_ready, resp_valid, resp_data, resp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, cmd_crc, resp_long,
    output cmd_ready, resp_valid, resp_data, resp_timeout
  );
endinterface

// File: rtl/sd_cmd_host.sv
// SPI-mode SD command engine: shifts out a 48-bit command frame, waits for the
// card's response start bit, captures an R1 or R7/R3 response, then idles sd_cs high.
module sd_cmd_host #(
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned GAP     = 8
) (
  input  logic              SD_CLK,
  input  logic              rst_n,
  sd_cmd_host_if.slave      cmd,
  output logic              sd_cs,
  output logic              sd_mosi,
  input  logic              sd_miso
);

  localparam int unsigned WaitW = $clog2(NCR_MAX + 1);
  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {StIdle, StSend, StWaitResp, StRecv, StGap} state_e;

  state_e            state_q;
  logic [47:0]       frame_q;
  logic              long_q;
  logic [5:0]        bit_cnt_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic [5:0]        rx_cnt_q;
  logic [38:0]       rx_q;
  logic [GapW-1:0]   gap_cnt_q;
  logic [47:0]       frame;

  assign frame = {2'b01, cmd.cmd_index, cmd.cmd_arg, cmd.cmd_crc, 1'b1};

  always_ff @(posedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      frame_q          <= '0;
      long_q           <= 1'b0;
      bit_cnt_q        <= '0;
      wait_cnt_q       <= '0;
      rx_cnt_q         <= '0;
      rx_q             <= '0;
      gap_cnt_q        <= '0;
      cmd.cmd_ready    <= 1'b1;
      cmd.resp_valid   <= 1'b0;
      cmd.resp_data    <= '0;
      cmd.resp_timeout <= 1'b0;
      sd_cs            <= 1'b1;
      sd_mosi          <= 1'b1;
    end else begin
      cmd.resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd.cmd_valid) begin
            // Bit 47 goes straight to the pin; frame_q holds the remaining bits left-aligned.
            frame_q       <= {frame[46:0], 1'b1};
            long_q        <= cmd.resp_long;
            bit_cnt_q     <= 6'd47;
            sd_cs         <= 1'b0;
            sd_mosi       <= frame[47];
            cmd.cmd_ready <= 1'b0;
            state_q       <= StSend;
          end
        end
        StSend: begin
          if (bit_cnt_q == 6'd0) begin
            sd_mosi    <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= StWaitResp;
          end else begin
            bit_cnt_q <= bit_cnt_q - 6'd1;
            sd_mosi   <= frame_q[47];
            frame_q   <= {frame_q[46:0], 1'b1};
          end
        end
        StWaitResp: begin
          if (!sd_miso) begin
            // The start bit is the response MSB and is always 0.
            rx_q     <= '0;
            rx_cnt_q <= long_q ? 6'd39 : 6'd7;
            state_q  <= StRecv;
          end else if (wait_cnt_q == WaitW'(NCR_MAX - 1)) begin
            cmd.resp_data    <= long_q ? '1 : 40'hFF;
            cmd.resp_timeout <= 1'b1;
            cmd.resp_valid   <= 1'b1;
            sd_cs            <= 1'b1;
            gap_cnt_q        <= GapW'(GAP - 1);
            state_q          <= StGap;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StRecv: begin
          if (rx_cnt_q == 6'd1) begin
            cmd.resp_data    <= {rx_q, sd_miso};
            cmd.resp_timeout <= 1'b0;
            cmd.resp_valid   <= 1'b1;
            sd_cs            <= 1'b1;
            gap_cnt_q        <= GapW'(GAP - 1);
            state_q          <= StGap;
          end else begin
            rx_cnt_q <= rx_cnt_q - 6'd1;
            rx_q     <= {rx_q[37:0], sd_miso};
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            cmd.cmd_ready <= 1'b1;
            state_q       <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
